trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Sits between the commit stage and the M-mode CSR file, directly upstream of the CSR trap-update logic.
- Selects between pending interrupts, synchronous exceptions and MRET at the commit boundary, then drives the trap-entry CSR writes (mepc, mcause, mtval, mstatus).
- Sequences the pipeline flush handshake and issues one fetch redirect to the trap vector or to mepc.
- M-mode only; no delegation.

Parameters:
- MXLEN, 64, register/address width.
- VECTORED_EN, 1, 1 allows mtvec.mode=VECTORED; 0 treats every mode as DIRECT.

Ports:
Interface: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- commit_valid_i  in  1  an instruction is at commit
- commit_pc_i  in  MXLEN  PC of the committing instruction
- commit_exception_i  in  1  the committing instruction raised a synchronous exception
- commit_cause_i  in  MXLEN-1  synchronous exception code
- commit_tval_i  in  MXLEN  trap value for the exception
- commit_mret_i  in  1  the committing instruction is MRET
- next_pc_i  in  MXLEN  next fetch PC, used as epc for interrupts taken while no commit is valid
- mip_i  in  MXLEN  mip CSR
- mie_i  in  MXLEN  mie CSR
- mstatus_mie_i  in  1  mstatus.MIE
- priv_lvl_i  in  2  current privilege level
- mtvec_i  in  MXLEN  mtvec CSR; base is bits [63:2], mode is bits [1:0]
- mepc_i  in  MXLEN  mepc CSR, used as the MRET target
- flush_ack_i  in  1  pipeline flush complete
- busy_o  out  1  sequencer is not IDLE; commit is stalled
- csr_we_o  out  1  write mepc, mcause and mtval this cycle
- mepc_o  out  MXLEN  value to write to mepc
- mcause_o  out  MXLEN  value to write to mcause; {interrupt, code}
- mtval_o  out  MXLEN  value to write to mtval
- mstatus_trap_o  out  1  pulse: MPIE<=MIE, MIE<=0, MPP<=priv
- mret_o  out  1  pulse: MIE<=MPIE, MPIE<=1, priv<=MPP
- flush_o  out  1  request pipeline flush
- redirect_valid_o  out  1  one-cycle fetch redirect
- redirect_pc_o  out  MXLEN  redirect target

Behaviour:
- Reset: state IDLE; every output 0, including the registered pc, cause and tval values. Reset asserted mid-sequence aborts to IDLE immediately with no CSR write and no redirect.
- Interrupt enable: pending = mip_i & mie_i & 0x2AAA (bits 1,3,5,7,9,11,13). Interrupts are globally enabled when priv_lvl_i != MACHINE, or when priv_lvl_i == MACHINE and mstatus_mie_i = 1.
- Interrupt priority: 11 > 3 > 7 > 9 > 1 > 5 > 13.
- Decision in IDLE (combinational on inputs; all values latched at the clock edge):
  - Enabled pending interrupt → go to TRAP. cause = {1, code}; epc = commit_valid_i ? commit_pc_i : next_pc_i; tval = 0. The committing instruction is not retired.
  - Else commit_valid_i & commit_exception_i → go to TRAP. cause = {0, commit_cause_i}; epc = commit_pc_i; tval = commit_tval_i.
  - Else commit_valid_i & commit_mret_i → go to MRET. target = mepc_i & ~3.
  - Otherwise stay in IDLE.
  - Resolution order when these coincide: interrupt > exception > MRET.
- TRAP (1 cycle):
  - csr_we_o = 1 and mstatus_trap_o = 1; mepc_o, mcause_o and mtval_o hold the latched values.
  - target = {mtvec_i[63:2], 2'b00}. If VECTORED_EN and mode == 1 and interrupt, add 4*code. Addition is modulo 2^MXLEN.
  - mode values 2 and 3 behave as DIRECT.
  - Next state: FLUSH.
- MRET (1 cycle): mret_o = 1. Next state: FLUSH.
- FLUSH: flush_o = 1 while in this state. Leave for REDIRECT on the first cycle flush_ack_i = 1, including the state's first cycle. No timeout.
- REDIRECT (1 cycle): redirect_valid_o = 1, redirect_pc_o = latched target. Next state: IDLE.
- Latency: decision edge → TRAP/MRET → FLUSH (≥1 cycle) → REDIRECT. Minimum 3 cycles from decision to redirect.
- While busy_o = 1, all commit_* inputs and interrupts are ignored. A pending interrupt is re-evaluated in IDLE after the redirect, against the updated mstatus.
- All outputs other than busy_o are 0 outside their state.

Test Plan:
- Exception: priv=M, commit_pc=0x8000_0010, cause=2, tval=0xDEAD, mtvec=0x8000_0100 → TRAP cycle shows csr_we_o=1, mepc_o=0x8000_0010, mcause_o=0x2, mtval_o=0xDEAD; flush_ack one cycle later; redirect_pc_o=0x8000_0100.
- Vectored interrupt: mtvec=0x8000_0101, mip=mie=0x80, MIE=1, no commit, next_pc=0x2000 → mcause_o=0x8000_0000_0000_0007, mepc_o=0x2000, mtval_o=0, redirect_pc_o=0x8000_011C.
- Priority and masking:
  - mip=mie=0x888 with an exception committing simultaneously → cause 11 taken and the exception is dropped.
  - With priv=M and MIE=0 → the exception (cause 2) is taken instead.
- MRET: mepc=0x4003 → mret_o pulses once; redirect_pc_o=0x4000; csr_we_o stays 0.
- Handshake: hold flush_ack_i=0 for 5 cycles → flush_o held 5 cycles, busy_o=1, no redirect; new commits are ignored. Then ack=1 → redirect on the next cycle.
- Reset mid-FLUSH: drop rstn_i → all outputs 0 asynchronously; no redirect after release.

Source files
------------

// File: rtl/trap_sequencer.sv
// M-mode trap/MRET sequencer: picks interrupt, exception or MRET at commit, drives
// the trap-entry CSR writes, runs the flush handshake and issues one fetch redirect.
module trap_sequencer #(
  parameter int MXLEN       = 64,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             commit_valid_i,
  input  logic [MXLEN-1:0] commit_pc_i,
  input  logic             commit_exception_i,
  input  logic [MXLEN-2:0] commit_cause_i,
  input  logic [MXLEN-1:0] commit_tval_i,
  input  logic             commit_mret_i,
  input  logic [MXLEN-1:0] next_pc_i,
  input  logic [MXLEN-1:0] mip_i,
  input  logic [MXLEN-1:0] mie_i,
  input  logic             mstatus_mie_i,
  input  logic [1:0]       priv_lvl_i,
  input  logic [MXLEN-1:0] mtvec_i,
  input  logic [MXLEN-1:0] mepc_i,
  input  logic             flush_ack_i,
  output logic             busy_o,
  output logic             csr_we_o,
  output logic [MXLEN-1:0] mepc_o,
  output logic [MXLEN-1:0] mcause_o,
  output logic [MXLEN-1:0] mtval_o,
  output logic             mstatus_trap_o,
  output logic             mret_o,
  output logic             flush_o,
  output logic             redirect_valid_o,
  output logic [MXLEN-1:0] redirect_pc_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAP,
    S_MRET,
    S_FLUSH,
    S_REDIRECT
  } state_t;

  localparam logic [1:0]       PRIV_M   = 2'b11;
  localparam logic [MXLEN-1:0] IRQ_MASK = MXLEN'(16'h2AAA);

  state_t           state_q, state_d;
  logic [MXLEN-1:0] epc_q, epc_d;
  logic [MXLEN-1:0] cause_q, cause_d;
  logic [MXLEN-1:0] tval_q, tval_d;
  logic [MXLEN-1:0] target_q, target_d;

  logic [MXLEN-1:0] pending;
  logic             irq_en;
  logic             irq_take;
  logic [3:0]       irq_code;
  logic [MXLEN-1:0] tvec_base;
  logic [MXLEN-1:0] tvec_off;
  logic             tvec_vectored;
  logic [MXLEN-1:0] trap_target;

  assign pending  = mip_i & mie_i & IRQ_MASK;
  assign irq_en   = (priv_lvl_i != PRIV_M) || mstatus_mie_i;
  assign irq_take = irq_en && (|pending);

  // Fixed priority 11 > 3 > 7 > 9 > 1 > 5 > 13.
  always_comb begin
    irq_code = 4'd0;
    if      (pending[11]) irq_code = 4'd11;
    else if (pending[3])  irq_code = 4'd3;
    else if (pending[7])  irq_code = 4'd7;
    else if (pending[9])  irq_code = 4'd9;
    else if (pending[1])  irq_code = 4'd1;
    else if (pending[5])  irq_code = 4'd5;
    else if (pending[13]) irq_code = 4'd13;
  end

  // 4*code taken from the latched cause; wraps modulo 2^MXLEN.
  assign tvec_base     = {mtvec_i[MXLEN-1:2], 2'b00};
  assign tvec_off      = {cause_q[MXLEN-3:0], 2'b00};
  assign tvec_vectored = VECTORED_EN && (mtvec_i[1:0] == 2'b01) && cause_q[MXLEN-1];
  assign trap_target   = tvec_vectored ? (tvec_base + tvec_off) : tvec_base;

  assign busy_o = (state_q != S_IDLE);

  always_comb begin
    state_d          = state_q;
    epc_d            = epc_q;
    cause_d          = cause_q;
    tval_d           = tval_q;
    target_d         = target_q;
    csr_we_o         = 1'b0;
    mepc_o           = '0;
    mcause_o         = '0;
    mtval_o          = '0;
    mstatus_trap_o   = 1'b0;
    mret_o           = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state_q)
      S_IDLE: begin
        if (irq_take) begin
          state_d = S_TRAP;
          cause_d = {1'b1, (MXLEN-1)'(irq_code)};
          epc_d   = commit_valid_i ? commit_pc_i : next_pc_i;
          tval_d  = '0;
        end else if (commit_valid_i && commit_exception_i) begin
          state_d = S_TRAP;
          cause_d = {1'b0, commit_cause_i};
          epc_d   = commit_pc_i;
          tval_d  = commit_tval_i;
        end else if (commit_valid_i && commit_mret_i) begin
          state_d  = S_MRET;
          target_d = mepc_i & ~MXLEN'(3);
        end
      end
      S_TRAP: begin
        csr_we_o       = 1'b1;
        mstatus_trap_o = 1'b1;
        mepc_o         = epc_q;
        mcause_o       = cause_q;
        mtval_o        = tval_q;
        target_d       = trap_target;
        state_d        = S_FLUSH;
      end
      S_MRET: begin
        mret_o  = 1'b1;
        state_d = S_FLUSH;
      end
      S_FLUSH: begin
        flush_o = 1'b1;
        if (flush_ack_i) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: expected trap/MRET records are queued at
// stimulus time and retired by a monitor when the DUT writes CSRs and redirects.
module tb_trap_sequencer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        commit_valid_i;
  logic [63:0] commit_pc_i;
  logic        commit_exception_i;
  logic [62:0] commit_cause_i;
  logic [63:0] commit_tval_i;
  logic        commit_mret_i;
  logic [63:0] next_pc_i;
  logic [63:0] mip_i;
  logic [63:0] mie_i;
  logic        mstatus_mie_i;
  logic [1:0]  priv_lvl_i;
  logic [63:0] mtvec_i;
  logic [63:0] mepc_i;
  logic        flush_ack_i;
  logic        busy_o;
  logic        csr_we_o;
  logic [63:0] mepc_o;
  logic [63:0] mcause_o;
  logic [63:0] mtval_o;
  logic        mstatus_trap_o;
  logic        mret_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;

  trap_sequencer #(.MXLEN(64), .VECTORED_EN(1'b1)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .commit_exception_i(commit_exception_i), .commit_cause_i(commit_cause_i),
    .commit_tval_i(commit_tval_i), .commit_mret_i(commit_mret_i),
    .next_pc_i(next_pc_i), .mip_i(mip_i), .mie_i(mie_i),
    .mstatus_mie_i(mstatus_mie_i), .priv_lvl_i(priv_lvl_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .flush_ack_i(flush_ack_i),
    .busy_o(busy_o), .csr_we_o(csr_we_o), .mepc_o(mepc_o),
    .mcause_o(mcause_o), .mtval_o(mtval_o), .mstatus_trap_o(mstatus_trap_o),
    .mret_o(mret_o), .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_mret;
    logic [63:0] epc;
    logic [63:0] cause;
    logic [63:0] tval;
    logic [63:0] target;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   redirects   = 0;
  int   mret_cnt    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input bit m, input logic [63:0] epc, input logic [63:0] cause,
                              input logic [63:0] tval, input logic [63:0] target);
    exp_t e;
    e.is_mret = m;
    e.epc     = epc;
    e.cause   = cause;
    e.tval    = tval;
    e.target  = target;
    return e;
  endfunction

  // Monitor: sample on the falling edge, retire scoreboard entries at redirect.
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (csr_we_o) begin
        if (sb.size() == 0) chk("unexpected_trap", 64'(csr_we_o), 64'd0);
        else begin
          chk("trap_not_mret", 64'(sb[0].is_mret), 64'd0);
          chk("mepc", mepc_o, sb[0].epc);
          chk("mcause", mcause_o, sb[0].cause);
          chk("mtval", mtval_o, sb[0].tval);
          chk("mstatus_trap", 64'(mstatus_trap_o), 64'd1);
        end
      end
      if (mret_o) begin
        mret_cnt++;
        if (sb.size() == 0) chk("unexpected_mret", 64'(mret_o), 64'd0);
        else chk("mret_expected", 64'(sb[0].is_mret), 64'd1);
        chk("mret_no_csr_we", 64'(csr_we_o), 64'd0);
      end
      if (redirect_valid_o) begin
        redirects++;
        if (sb.size() == 0) chk("unexpected_redirect", 64'(redirect_valid_o), 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("redirect_pc", redirect_pc_o, e.target);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  task automatic idle_inputs();
    commit_valid_i     = 1'b0;
    commit_exception_i = 1'b0;
    commit_mret_i      = 1'b0;
    mip_i              = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy_o && cycles < budget) begin
      step();
      cycles++;
    end
    if (busy_o) chk("timeout_busy", 64'(busy_o), 64'd0);
  endtask

  // Inputs already driven; decision at the next edge, then run to IDLE.
  task automatic issue(input exp_t e, input int exp_busy);
    int c;
    sb.push_back(e);
    step();
    idle_inputs();
    wait_idle(30, c);
    chk("busy_cycles", 64'(c), 64'(exp_busy));
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_busy"}, 64'(busy_o), 64'd0);
    chk({pfx, "_csr_we"}, 64'(csr_we_o), 64'd0);
    chk({pfx, "_mepc"}, mepc_o, 64'd0);
    chk({pfx, "_mcause"}, mcause_o, 64'd0);
    chk({pfx, "_mtval"}, mtval_o, 64'd0);
    chk({pfx, "_mst_trap"}, 64'(mstatus_trap_o), 64'd0);
    chk({pfx, "_mret"}, 64'(mret_o), 64'd0);
    chk({pfx, "_flush"}, 64'(flush_o), 64'd0);
    chk({pfx, "_redir_v"}, 64'(redirect_valid_o), 64'd0);
    chk({pfx, "_redir_pc"}, redirect_pc_o, 64'd0);
  endtask

  logic [63:0] pri_mip [4];
  int          pri_code[4];

  initial begin
    int r0;
    int m0;
    rstn_i         = 1'b0;
    idle_inputs();
    commit_pc_i    = '0;
    commit_cause_i = '0;
    commit_tval_i  = '0;
    next_pc_i      = '0;
    mie_i          = '0;
    mstatus_mie_i  = 1'b1;
    priv_lvl_i     = 2'b11;
    mtvec_i        = 64'h8000_0100;
    mepc_i         = '0;
    flush_ack_i    = 1'b1;
    #2;
    check_all_zero("reset");
    step();
    step();
    rstn_i = 1'b1;
    step();

    // Synchronous exception, direct vector.
    commit_valid_i = 1'b1; commit_exception_i = 1'b1;
    commit_pc_i = 64'h8000_0010; commit_cause_i = 63'd2; commit_tval_i = 64'hDEAD;
    issue(mk(0, 64'h8000_0010, 64'h2, 64'hDEAD, 64'h8000_0100), 3);

    // Vectored interrupt with no commit.
    mtvec_i = 64'h8000_0101; mip_i = 64'h80; mie_i = 64'h80; next_pc_i = 64'h2000;
    issue(mk(0, 64'h2000, 64'h8000_0000_0000_0007, 64'h0, 64'h8000_011C), 3);

    // Interrupt beats a coincident exception.
    mtvec_i = 64'h8000_0100; mip_i = 64'h888; mie_i = 64'h888;
    commit_valid_i = 1'b1; commit_exception_i = 1'b1;
    commit_pc_i = 64'h8000_0020; commit_cause_i = 63'd2; commit_tval_i = 64'h55;
    issue(mk(0, 64'h8000_0020, 64'h8000_0000_0000_000B, 64'h0, 64'h8000_0100), 3);

    // M-mode with MIE=0 masks it; the exception wins.
    mstatus_mie_i = 1'b0; mip_i = 64'h888;
    commit_valid_i = 1'b1; commit_exception_i = 1'b1;
    commit_pc_i = 64'h8000_0020; commit_cause_i = 63'd2; commit_tval_i = 64'h55;
    issue(mk(0, 64'h8000_0020, 64'h2, 64'h55, 64'h8000_0100), 3);

    // Below M-mode interrupts are enabled regardless of MIE; 1 beats 5.
    priv_lvl_i = 2'b00; mtvec_i = 64'h8000_0101;
    mip_i = 64'h22; mie_i = 64'h22; next_pc_i = 64'h3000;
    issue(mk(0, 64'h3000, 64'h8000_0000_0000_0001, 64'h0, 64'h8000_0104), 3);
    priv_lvl_i = 2'b11; mstatus_mie_i = 1'b1;

    // Pairwise priority, vectored so the target also encodes the code.
    pri_mip[0] = 64'h280;  pri_code[0] = 7;
    pri_mip[1] = 64'h202;  pri_code[1] = 9;
    pri_mip[2] = 64'h2020; pri_code[2] = 5;
    pri_mip[3] = 64'h88;   pri_code[3] = 3;
    for (int i = 0; i < 4; i++) begin
      mip_i = pri_mip[i]; mie_i = pri_mip[i]; next_pc_i = 64'h5000 + 64'(i);
      issue(mk(0, 64'h5000 + 64'(i), {1'b1, 63'(pri_code[i])}, 64'h0,
               64'h8000_0100 + 64'(4 * pri_code[i])), 3);
    end

    // Mode 3 behaves as DIRECT.
    mtvec_i = 64'h8000_0103; mip_i = 64'h2000; mie_i = 64'h2000; next_pc_i = 64'h6000;
    issue(mk(0, 64'h6000, 64'h8000_0000_0000_000D, 64'h0, 64'h8000_0100), 3);

    // Vector offset wraps modulo 2^64.
    mtvec_i = 64'hFFFF_FFFF_FFFF_FFFD; mip_i = 64'h8; mie_i = 64'h8; next_pc_i = 64'h7000;
    issue(mk(0, 64'h7000, 64'h8000_0000_0000_0003, 64'h0, 64'h8), 3);

    // Unmaskable-bit patterns and disabled mie never trap.
    mtvec_i = 64'h8000_0100;
    mip_i = 64'h1555; mie_i = 64'h1555;
    step(); step();
    chk("no_trap_even_bits", 64'(busy_o), 64'd0);
    mip_i = 64'h80; mie_i = 64'h0;
    step(); step();
    chk("no_trap_mie_zero", 64'(busy_o), 64'd0);
    idle_inputs();

    // MRET.
    m0 = mret_cnt;
    commit_valid_i = 1'b1; commit_mret_i = 1'b1; mepc_i = 64'h4003;
    issue(mk(1, 64'h0, 64'h0, 64'h0, 64'h4000), 3);
    chk("mret_pulses", 64'(mret_cnt - m0), 64'd1);

    // Exception beats MRET; interrupt beats MRET.
    commit_valid_i = 1'b1; commit_mret_i = 1'b1; commit_exception_i = 1'b1;
    commit_pc_i = 64'h9000; commit_cause_i = 63'd11; commit_tval_i = 64'h0;
    issue(mk(0, 64'h9000, 64'hB, 64'h0, 64'h8000_0100), 3);
    mie_i = 64'h800; mip_i = 64'h800;
    commit_valid_i = 1'b1; commit_mret_i = 1'b1; commit_pc_i = 64'h9100;
    issue(mk(0, 64'h9100, 64'h8000_0000_0000_000B, 64'h0, 64'h8000_0100), 3);

    // Held flush handshake; commits during busy are ignored.
    flush_ack_i = 1'b0; r0 = redirects;
    commit_valid_i = 1'b1; commit_exception_i = 1'b1;
    commit_pc_i = 64'h100; commit_cause_i = 63'd5; commit_tval_i = 64'h77;
    sb.push_back(mk(0, 64'h100, 64'h5, 64'h77, 64'h8000_0100));
    step();
    commit_pc_i = 64'h200; commit_cause_i = 63'd7; commit_tval_i = 64'h99; mip_i = 64'h800;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_flush", 64'(flush_o), 64'd1);
      chk("hold_busy", 64'(busy_o), 64'd1);
      chk("hold_no_redirect", 64'(redirect_valid_o), 64'd0);
      step();
    end
    chk("hold_redirect_count", 64'(redirects - r0), 64'd0);
    flush_ack_i = 1'b1;
    step();
    chk("ack_redirect", 64'(redirect_valid_o), 64'd1);
    idle_inputs();
    step();
    chk("ack_idle", 64'(busy_o), 64'd0);
    step(); step();
    chk("ignored_commit_no_trap", 64'(busy_o), 64'd0);

    // Reset mid-FLUSH aborts with no redirect.
    flush_ack_i = 1'b0; r0 = redirects;
    commit_valid_i = 1'b1; commit_exception_i = 1'b1;
    commit_pc_i = 64'h300; commit_cause_i = 63'd4; commit_tval_i = 64'h11;
    sb.push_back(mk(0, 64'h300, 64'h4, 64'h11, 64'h8000_0100));
    step();
    idle_inputs();
    step();
    chk("pre_reset_flush", 64'(flush_o), 64'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    check_all_zero("async_rst");
    sb.delete();
    step(); step();
    rstn_i = 1'b1;
    flush_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("post_reset_no_redirect", 64'(redirects - r0), 64'd0);
    chk("post_reset_idle", 64'(busy_o), 64'd0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
